// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EXE stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0,
    parameter int RD_W     = 5
) (
    input  logic            Clock,
    input  logic            nReset,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [RD_W-1:0] rd,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out
);

    localparam int  CW   = $clog2(XLEN);
    localparam bit  FAST = (FAST_MUL != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic [RD_W-1:0]     rd_out_q, rd_out_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [2*XLEN-1:0]   work_q, work_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode for the request presented in IDLE
    logic                is_div;
    logic                sgn1, sgn2, s1, s2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div0, ovf, fast_op, special;
    logic                neg_in;
    logic [2*XLEN-1:0]   fprod, fprod_s;
    logic [XLEN-1:0]     spec_res;

    always_comb begin
        is_div  = func3[2];
        sgn1    = is_div ? ~func3[0] : (func3[1] ^ func3[0]);
        sgn2    = is_div ? ~func3[0] : (func3 == 3'b001);
        s1      = sgn1 & rs1[XLEN-1];
        s2      = sgn2 & rs2[XLEN-1];
        mag1    = s1 ? -rs1 : rs1;
        mag2    = s2 ? -rs2 : rs2;
        div0    = is_div & (rs2 == '0);
        ovf     = is_div & ~func3[0]
                & (rs1 == {1'b1, {(XLEN-1){1'b0}}})
                & (rs2 == '1);
        fast_op = FAST & ~is_div;
        special = div0 | ovf | fast_op;
        neg_in  = (is_div & func3[1]) ? s1 : (s1 ^ s2);
        fprod   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        fprod_s = neg_in ? -fprod : fprod;
        spec_res = '0;
        unique case (1'b1)
            div0:    spec_res = func3[1] ? rs1 : '1;
            ovf:     spec_res = func3[1] ? '0 : rs1;
            default: spec_res = (func3[1:0] == 2'b00)
                              ? fprod_s[XLEN-1:0]
                              : fprod_s[2*XLEN-1:XLEN];
        endcase
    end

    // One radix-2 step of either algorithm on the shared work register
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_sh, diff;
    logic [2*XLEN-1:0]   mul_nxt, div_nxt, step;
    logic [2*XLEN-1:0]   step_s;
    logic [XLEN-1:0]     div_val, calc_res;

    always_comb begin
        mul_sum = {1'b0, work_q[2*XLEN-1:XLEN]}
                + (work_q[0] ? {1'b0, mcand_q} : '0);
        mul_nxt = {mul_sum, work_q[XLEN-1:1]};
        rem_sh  = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        diff    = rem_sh - {1'b0, mcand_q};
        div_nxt = diff[XLEN]
                ? {rem_sh[XLEN-1:0], work_q[XLEN-2:0], 1'b0}
                : {diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
        step    = op_q[2] ? div_nxt : mul_nxt;
        step_s  = neg_q ? -step : step;
        div_val = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        if (op_q[2]) begin
            calc_res = neg_q ? -div_val : div_val;
        end else if (op_q[1:0] == 2'b00) begin
            calc_res = step_s[XLEN-1:0];
        end else begin
            calc_res = step_s[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        mcand_d  = mcand_q;
        work_d   = work_q;
        neg_d    = neg_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d    = func3;
                        rd_d    = rd;
                        mcand_d = mag2;
                        work_d  = {{XLEN{1'b0}}, mag1};
                        neg_d   = neg_in;
                        cnt_d   = '0;
                        if (special) begin
                            state_d  = S_DONE;
                            result_d = spec_res;
                            rd_out_d = rd;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    work_d = step;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_d  = S_DONE;
                        result_d = calc_res;
                        rd_out_d = rd_q;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            mcand_q  <= '0;
            work_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            mcand_q  <= mcand_d;
            work_q   <= work_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // busy is combinational so the pipeline holds in the start cycle
    assign busy   = nReset & ((state_q == S_CALC)
                  | ((state_q == S_IDLE) & start & ~flush));
    assign done   = nReset & ~flush & (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule
